// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, frame edge count and default timing parameters.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAIT_REL
    } ps2_state_e;

    // Falling edges per host-to-device frame: 10 shifted bits plus the ack slot
    localparam int FRAME_EDGES     = 11;
    localparam int DEF_INHIBIT_CYC = 5000;
    localparam int DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side bundle of the PS/2 host transmitter, with the FSM state exposed for observation.
// Handshake: a byte transfers on a rising clk_i edge where tx_valid_i && tx_ready_o; done_o,
// ack_err_o and tmo_err_o are single-cycle pulses that need no acknowledgement.
interface ps2_host_tx_if;
    import ps2_tx_pkg::*;

    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       done_o;
    logic       ack_err_o;
    logic       tmo_err_o;
    ps2_state_e dbg_state;

    modport slave (
        input  tx_valid_i, tx_data_i,
        output tx_ready_o, done_o, ack_err_o, tmo_err_o, dbg_state
    );

    modport master (
        output tx_valid_i, tx_data_i,
        input  tx_ready_o, done_o, ack_err_o, tmo_err_o, dbg_state
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line, with a registered falling-edge flag.
// The line idles high, so every stage resets to 1 and no spurious edge appears after reset.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic sync_o,
    output logic fe_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic fe_q, fe_d;

    always_comb begin
        meta_d = line_i;
        sync_d = meta_q;
        prev_d = sync_q;
        fe_d   = prev_q & ~sync_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fe_q   <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            fe_q   <= fe_d;
        end
    end

    assign sync_o = sync_q;
    assign fe_o   = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock edges, check the ack, and guard the frame with a watchdog.
module ps2_host_tx
    import ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_i,
    input  logic         ps2_dat_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_dat_oe_o
);

    if (INHIBIT_CYC < 2 || TIMEOUT_CYC <= INHIBIT_CYC) begin : g_bad_params
        $error("ps2_host_tx: need INHIBIT_CYC >= 2 and TIMEOUT_CYC > INHIBIT_CYC");
    end

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYC - 1);
    localparam logic [IW-1:0] INH_MAX    = IW'(INHIBIT_CYC);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [3:0]    LAST_SHIFT = 4'(FRAME_EDGES - 2);

    ps2_state_e    state_q, state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] wd_cnt_q, wd_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          nack_q, nack_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          tmo_q, tmo_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          wd_active;

    logic clk_s, clk_fe, dat_s, dat_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (ps2_clk_i),
        .sync_o (clk_s),
        .fe_o   (clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (ps2_dat_i),
        .sync_o (dat_s),
        .fe_o   (dat_fe_unused)
    );

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        nack_d    = nack_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        tmo_d     = 1'b0;
        wd_active = 1'b0;

        case (state_q)
            IDLE: begin
                dat_oe_d  = 1'b0;
                inh_cnt_d = '0;
                wd_cnt_d  = '0;
                if (tx.tx_valid_i && ready_q) begin
                    shift_d = {1'b1, ~^tx.tx_data_i, tx.tx_data_i};
                    nack_d  = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                wd_cnt_d  = '0;
                inh_cnt_d = (inh_cnt_q == INH_MAX) ? inh_cnt_q : inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                wd_active = 1'b1;
                bit_cnt_d = '0;
                state_d   = XFER;
            end
            XFER: begin
                wd_active = 1'b1;
                // Line is driven low for a 0 bit, hence the inversion
                if (clk_fe) begin
                    dat_oe_d  = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_SHIFT) state_d = ACK;
                end
            end
            ACK: begin
                wd_active = 1'b1;
                if (clk_fe) begin
                    nack_d  = dat_s;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                wd_active = 1'b1;
                if (clk_s && dat_s) begin
                    done_d    = 1'b1;
                    ack_err_d = nack_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides any normal completion in the same cycle
        if (wd_active) begin
            wd_cnt_d = (wd_cnt_q == TMO_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
            if (wd_cnt_q == TMO_LAST) begin
                state_d   = IDLE;
                dat_oe_d  = 1'b0;
                done_d    = 1'b0;
                ack_err_d = 1'b0;
                tmo_d     = 1'b1;
            end
        end

        ready_d  = (state_d == IDLE);
        clk_oe_d = (state_d == INHIBIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            wd_cnt_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            nack_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            tmo_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            nack_q    <= nack_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            tmo_q     <= tmo_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    assign tx.tx_ready_o = ready_q;
    assign tx.done_o     = done_q;
    assign tx.ack_err_o  = ack_err_q;
    assign tx.tmo_err_o  = tmo_q;
    assign tx.dbg_state  = state_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_dat_oe_o  = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines, a table of
// command frames with hand-computed bit patterns, and sequences for timeout, reset and held valid.
module tb_ps2_host_tx;
    import ps2_tx_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_frame;
        bit         exp_err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_host_tx_if tx_if ();
    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx           (tx_if),
        .ps2_clk_i    (ps2_clk_line),
        .ps2_dat_i    (ps2_dat_line),
        .ps2_clk_oe_o (ps2_clk_oe),
        .ps2_dat_oe_o (ps2_dat_oe)
    );

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int done_cnt = 0, ack_err_cnt = 0, err_alone_cnt = 0, tmo_cnt = 0;
    int last_done_cyc = 0, last_tmo_cyc = 0;
    int oe_rise_cyc = 0, oe_fall_cyc = 0, oe_run = 0, last_inh_len = 0;
    bit oe_prev = 1'b0;
    bit stop_rand;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_if.done_o) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (tx_if.ack_err_o) begin
            ack_err_cnt++;
            if (!tx_if.done_o) err_alone_cnt++;
        end
        if (tx_if.tmo_err_o) begin
            tmo_cnt++;
            last_tmo_cyc = cyc;
        end
        if (ps2_clk_oe) begin
            if (!oe_prev) oe_rise_cyc = cyc;
            oe_run++;
        end else if (oe_prev) begin
            last_inh_len = oe_run;
            oe_run       = 0;
            oe_fall_cyc  = cyc;
        end
        oe_prev = ps2_clk_oe;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        rdy = 1'b0;
        for (int n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            if (tx_if.tx_ready_o) rdy = 1'b1;
        end
        if (!rdy) begin
            check("ready_wait", 0, 1);
            return;
        end
        tx_if.tx_valid_i = 1'b1;
        tx_if.tx_data_i  = b;
        @(posedge clk);
        #1;
        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = 8'($urandom_range(0, 255));
    endtask

    // Device side: waits for request-to-send, clocks 10 bits in, then optionally acks.
    task automatic device_rx(input bit ack, input int abort_fe, output logic [10:0] bits, output bit ok);
        bit found;
        ok    = 1'b0;
        bits  = '0;
        found = 1'b0;
        for (int n = 0; n < INH + 100 && !found; n++) begin
            @(negedge clk);
            if (ps2_clk_line && !ps2_dat_line && !ps2_clk_oe) found = 1'b1;
        end
        if (!found) return;
        repeat (HALF) @(negedge clk);
        bits[0] = ps2_dat_line;
        for (int e = 1; e <= 10; e++) begin
            dev_clk_low = 1'b1;
            if (e == abort_fe) begin
                repeat (6) @(negedge clk);
                ok = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            bits[e]     = ps2_dat_line;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (ack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_dat_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_done(input int base, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (done_cnt != base) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int b_done, b_err;
        logic [10:0] bits, exp;
        bit ok, seen;
        b_done = done_cnt;
        b_err  = ack_err_cnt;
        exp_q.push_back({v.exp_frame, 1'b0});
        send_byte(v.data);
        device_rx(v.ack, 0, bits, ok);
        check($sformatf("request_%02h", v.data), 32'(ok), 1);
        exp = exp_q.pop_front();
        check($sformatf("frame_bits_%02h", v.data), 32'(bits), 32'(exp));
        wait_done(b_done, seen);
        check($sformatf("done_seen_%02h", v.data), 32'(seen), 1);
        repeat (5) @(negedge clk);
        check($sformatf("done_once_%02h", v.data), done_cnt - b_done, 1);
        check($sformatf("ack_err_%02h", v.data), ack_err_cnt - b_err, 32'(v.exp_err));
        check($sformatf("inhibit_len_%02h", v.data), last_inh_len, INH);
        check($sformatf("ready_after_%02h", v.data), 32'(tx_if.tx_ready_o), 1);
    endtask

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [10:0] bits;
        bit ok, seen, found;
        int b_done, b_tmo, first_done;

        vecs[0] = '{data: 8'hED, ack: 1'b1, exp_frame: 10'h3ED, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, ack: 1'b1, exp_frame: 10'h300, exp_err: 1'b0};
        vecs[2] = '{data: 8'hFF, ack: 1'b1, exp_frame: 10'h3FF, exp_err: 1'b0};
        vecs[3] = '{data: 8'h01, ack: 1'b1, exp_frame: 10'h201, exp_err: 1'b0};
        vecs[4] = '{data: 8'hA5, ack: 1'b0, exp_frame: 10'h3A5, exp_err: 1'b1};
        vecs[5] = '{data: 8'hF4, ack: 1'b1, exp_frame: 10'h2F4, exp_err: 1'b0};

        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = 8'h00;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_if.tx_ready_o), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 0);
        check("rst_pulses", {29'd0, tx_if.done_o, tx_if.ack_err_o, tx_if.tmo_err_o}, 0);
        check("rst_state", 32'(tx_if.dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(tx_if.tx_ready_o), 1);

        // Device clock edges while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        check("idle_fe_state", 32'(tx_if.dbg_state), 32'(IDLE));
        check("idle_fe_dat_oe", 32'(ps2_dat_oe), 0);
        check("idle_fe_done", done_cnt, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Device never clocks: watchdog
        b_done = done_cnt;
        b_tmo  = tmo_cnt;
        send_byte(8'h12);
        seen = 1'b0;
        for (int n = 0; n < INH + TMO + 100 && !seen; n++) begin
            @(negedge clk);
            if (tmo_cnt != b_tmo) seen = 1'b1;
        end
        check("tmo_seen", 32'(seen), 1);
        check("tmo_latency", last_tmo_cyc - oe_fall_cyc, TMO);
        @(negedge clk);
        check("tmo_clk_oe", 32'(ps2_clk_oe), 0);
        check("tmo_dat_oe", 32'(ps2_dat_oe), 0);
        check("tmo_ready", 32'(tx_if.tx_ready_o), 1);
        check("tmo_no_done", done_cnt - b_done, 0);

        // Reset asserted with the device holding the clock low at fe 5
        send_byte(8'h66);
        device_rx(1'b1, 5, bits, ok);
        check("abort_request", 32'(ok), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_clk_oe", 32'(ps2_clk_oe), 0);
        check("abort_dat_oe", 32'(ps2_dat_oe), 0);
        check("abort_state", 32'(tx_if.dbg_state), 32'(IDLE));
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready_first_edge", 32'(tx_if.tx_ready_o), 1);
        run_vec(vecs[5]);

        // tx_valid held through a frame while tx_data wanders
        b_done = done_cnt;
        @(negedge clk);
        tx_if.tx_valid_i = 1'b1;
        tx_if.tx_data_i  = 8'h3C;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (ps2_clk_oe) found = 1'b1;
        end
        check("held_start", 32'(found), 1);
        stop_rand = 1'b0;
        fork
            begin
                device_rx(1'b1, 0, bits, ok);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(negedge clk);
                    tx_if.tx_data_i = 8'($urandom_range(0, 255));
                end
            end
        join
        tx_if.tx_data_i = 8'h55;
        check("held_frame_bits", 32'(bits), 32'({10'h33C, 1'b0}));
        wait_done(b_done, seen);
        check("held_done", 32'(seen), 1);
        first_done = last_done_cyc;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (ps2_clk_oe) found = 1'b1;
        end
        tx_if.tx_valid_i = 1'b0;
        check("held_second_start", 32'(found), 1);
        check("held_after_done", 32'(oe_rise_cyc > first_done), 1);
        device_rx(1'b1, 0, bits, ok);
        check("held_second_bits", 32'(bits), 32'({10'h355, 1'b0}));
        wait_done(b_done + 1, seen);
        check("held_second_done", 32'(seen), 1);

        repeat (5) @(negedge clk);
        check("ack_err_without_done", err_alone_cnt, 0);
        check("tmo_total", tmo_cnt, 1);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYC, default 5000, meaning clk_i cycles the clock line is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 1000000, meaning the frame watchdog limit in clk_i cycles (20 ms at 50 MHz).
REQ-003 Port clk_i, input, width 1: single clock; all logic is clocked on its rising edge.
REQ-004 Port rst_i, input, width 1: reset, asynchronous and active-high.
REQ-005 Port tx_valid_i, input, width 1: command byte valid.
REQ-006 Port tx_data_i, input, width 8: command byte.
REQ-007 Port tx_ready_o, output, width 1: block is idle and accepts a byte.
REQ-008 Port done_o, output, width 1: one-cycle pulse at frame end.
REQ-009 Port ack_err_o, output, width 1: one-cycle pulse, coincident with done_o, when the device did not acknowledge.
REQ-010 Port tmo_err_o, output, width 1: one-cycle pulse when the watchdog expires.
REQ-011 Port ps2_clk_i, input, width 1: raw PS/2 clock line level.
REQ-012 Port ps2_dat_i, input, width 1: raw PS/2 data line level.
REQ-013 Port ps2_clk_oe_o, output, width 1: 1 pulls the clock line low (open-drain); 0 releases it.
REQ-014 Port ps2_dat_oe_o, output, width 1: 1 pulls the data line low (open-drain); 0 releases it.

Function
REQ-015 ps2_clk_i and ps2_dat_i SHALL pass through 2-flop synchronizers; a falling edge (fe) SHALL be flagged one cycle after the synchronized clock goes 1->0.
REQ-016 The FSM SHALL have these states: IDLE, INHIBIT, REQ, XFER, ACK, WAIT_REL.
REQ-017 IDLE: tx_ready_o=1 and both oe outputs are 0; a tx_valid_i&&tx_ready_o handshake SHALL latch {stop=1, parity=~^tx_data_i, tx_data_i} into an 10-bit shift register and move the FSM to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe_o=1; a counter SHALL run 0..INHIBIT_CYC-1; on the last count ps2_dat_oe_o goes to 1 (start bit) and the FSM moves to REQ.
REQ-019 REQ: ps2_clk_oe_o=0 and ps2_dat_oe_o=1; the FSM moves to XFER, with the bit counter set to 0, on the next cycle.
REQ-020 XFER: on each fe, ps2_dat_oe_o SHALL take ~shift[0], the register shifts right, and the bit counter increments; fe 1..8 send data LSB-first, fe 9 sends parity, and fe 10 sends the stop bit (oe=0); after fe 10 the FSM moves to ACK.
REQ-021 ACK: on fe 11 the block SHALL sample the synchronized data line; 0 means acked, 1 means ack_err; the FSM then moves to WAIT_REL.
REQ-022 WAIT_REL: once the synchronized clock and data are both 1, the block SHALL pulse done_o (plus ack_err_o if not acked) and return to IDLE.
REQ-023 The watchdog SHALL start at INHIBIT exit and count while the FSM is in REQ, XFER, ACK or WAIT_REL; at TIMEOUT_CYC it SHALL release both lines, pulse tmo_err_o (not done_o), and go to IDLE.
REQ-024 tx_valid_i outside IDLE SHALL be ignored (no queueing), and tx_data_i SHALL be sampled only at the handshake.
REQ-025 fe while the FSM is in IDLE or INHIBIT SHALL be ignored.
REQ-026 Counter widths SHALL be $clog2(INHIBIT_CYC+1) and $clog2(TIMEOUT_CYC+1); both counters saturate and never wrap.
REQ-027 Parameters SHALL satisfy INHIBIT_CYC>=2 and TIMEOUT_CYC>INHIBIT_CYC; elaboration SHALL fail otherwise.

Reset
REQ-028 While rst_i=1 the FSM SHALL be in IDLE, all counters and the shift register 0, synchronizers 1, oe outputs 0, tx_ready_o 0, and the pulse outputs 0.
REQ-029 Reset asserted mid-frame SHALL release both lines asynchronously.
REQ-030 After rst_i falls, tx_ready_o SHALL rise on the first clk_i edge.

Structure
REQ-031 Package ps2_tx_pkg SHALL hold the FSM state enum, the frame length constant (11 edges), and the default parameter values.
REQ-032 Sub-module ps2_line_sync SHALL contain the 2-flop synchronizer plus falling-edge detect, with one instance per line.

Verification
REQ-033 Device model clocks at 12 kHz; tx 0xED -> device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model acks; one done_o pulse, ack_err_o=0.
REQ-034 tx 0x00 and 0xFF -> parity 1 in both; tx 0x01 -> parity 0; ps2_clk_oe_o high for exactly INHIBIT_CYC cycles before each frame.
REQ-035 Device model does not drive the ack at fe 11 -> done_o and ack_err_o pulse together in the same cycle.
REQ-036 Device never clocks after the request -> tmo_err_o pulses TIMEOUT_CYC cycles after INHIBIT exit, both oe outputs are 0, tx_ready_o=1, no done_o.
REQ-037 rst_i asserted at fe 5 -> both oe outputs are 0 in the same cycle; after release a new 0xF4 frame completes cleanly.
REQ-038 tx_valid_i held high through a frame with changing tx_data_i -> only the handshaked byte is sent; the next byte starts only after done_o.
